// File: rtl/clock_multi.sv
// clock_multi: multi-channel programmable clock generator.
// Each channel divides clk into a clock with runtime-programmable high and
// low phase lengths. New lengths are written into a shadow copy and move to
// the active copy only at a period boundary, so a period never changes shape
// while it is running.
module clock_multi #(
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int LEN    = 25,
    parameter int DEF_HI = 25000000,
    parameter int DEF_LO = 25000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic           wr_sel,
    input  logic [LEN-1:0] wr_data,
    output logic [NCH-1:0] clkout,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] pend
);

    localparam logic [LEN-1:0] HI_RST = LEN'(DEF_HI);
    localparam logic [LEN-1:0] LO_RST = LEN'(DEF_LO);
    localparam logic [LEN-1:0] ONE    = LEN'(1);

    // One channel's programme: high- and low-phase lengths in clk cycles.
    typedef struct packed {
        logic [LEN-1:0] hi;
        logic [LEN-1:0] lo;
    } len_pair_t;

    logic [LEN-1:0] ctr_q [NCH];
    logic [LEN-1:0] ctr_d [NCH];
    len_pair_t      act_q [NCH];
    len_pair_t      act_d [NCH];
    len_pair_t      shd_q [NCH];
    len_pair_t      shd_d [NCH];
    logic [LEN-1:0] h_eff [NCH];
    logic [LEN-1:0] l_eff [NCH];

    logic [NCH-1:0] clkout_d;
    logic [NCH-1:0] rise_d;
    logic [NCH-1:0] fall_d;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] bnd;

    // Decode the shared write port; an out-of-range channel hits nothing.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    // Effective phase lengths: a programmed length of 0 behaves as 1.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            h_eff[i] = (act_q[i].hi == '0) ? ONE : act_q[i].hi;
            l_eff[i] = (act_q[i].lo == '0) ? ONE : act_q[i].lo;
        end
    end

    // Per-channel next state: disable, sync, phase counting, apply and write.
    always_comb begin
        bnd = '0;
        for (int i = 0; i < NCH; i++) begin
            // NOTE: every output of this block is given a value before any
            // branch, so no path can leave it unassigned and infer a latch.
            ctr_d[i]    = ctr_q[i];
            act_d[i]    = act_q[i];
            shd_d[i]    = shd_q[i];
            clkout_d[i] = clkout[i];
            rise_d[i]   = 1'b0;
            fall_d[i]   = 1'b0;
            pend_d[i]   = pend[i];

            if (!en[i]) begin
                // Parked high with a cleared counter; config flows straight through.
                ctr_d[i]    = '0;
                clkout_d[i] = 1'b1;
                bnd[i]      = 1'b1;
            end else if (sync) begin
                ctr_d[i]    = '0;
                clkout_d[i] = 1'b1;
                rise_d[i]   = !clkout[i];
                bnd[i]      = 1'b1;
            end else if (clkout[i]) begin
                // '>=' lets a freshly shortened phase end at once instead of
                // counting all the way round the counter.
                if (ctr_q[i] >= h_eff[i] - ONE) begin
                    ctr_d[i]    = '0;
                    clkout_d[i] = 1'b0;
                    fall_d[i]   = 1'b1;
                end else begin
                    ctr_d[i] = ctr_q[i] + ONE;
                end
            end else begin
                if (ctr_q[i] >= l_eff[i] - ONE) begin
                    ctr_d[i]    = '0;
                    clkout_d[i] = 1'b1;
                    rise_d[i]   = 1'b1;
                    bnd[i]      = 1'b1;
                end else begin
                    ctr_d[i] = ctr_q[i] + ONE;
                end
            end

            // The boundary takes the shadow as it stood before this cycle's write.
            if (bnd[i] && pend[i]) begin
                act_d[i]  = shd_q[i];
                pend_d[i] = 1'b0;
            end

            if (wr_hit[i]) begin
                if (wr_sel) begin
                    shd_d[i].lo = wr_data;
                end else begin
                    shd_d[i].hi = wr_data;
                end
                pend_d[i] = 1'b1;
            end
        end
    end

    // State register; reset restores the default programme on every channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these arrays are a handful of per-channel registers, not a
            // RAM, so resetting every entry is intended and cheap.
            for (int i = 0; i < NCH; i++) begin
                ctr_q[i] <= '0;
                act_q[i] <= '{hi: HI_RST, lo: LO_RST};
                shd_q[i] <= '{hi: HI_RST, lo: LO_RST};
            end
            clkout <= '1;
            rise   <= '0;
            fall   <= '0;
            pend   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, regardless of statement order.
            ctr_q  <= ctr_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            clkout <= clkout_d;
            rise   <= rise_d;
            fall   <= fall_d;
            pend   <= pend_d;
        end
    end

endmodule
